seg7_display_reader: RTL and testbench

//   Receive-side counterpart of the switch/button seven-segment decoder. It

---
 rtl/seg7_display_reader.sv | 161 ++++++++++++++++
 tb/tb_seg7_display_reader.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/seg7_display_reader.sv
// Rebuilds the hex value shown on a multiplexed seven-segment bus, one nibble per digit.
// Latency: pins constant from edge k are captured at edge k+STABLE_CYCLES+1; frame_valid lags by one more edge.
// No backpressure: purely observing; a digit must dwell STABLE_CYCLES+1 samples to be captured.
// Ports: clk/rst_n; s_a..s_g, dp, anode (display bus pins); clear (sync wipe);
//        value/dp_out/digit_valid (per-digit capture), frame_valid (all digits valid), pattern_err (bad glyph pulse).
module seg7_display_reader #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4,
    parameter int ACTIVE_LOW    = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_a,
    input  logic                    s_b,
    input  logic                    s_c,
    input  logic                    s_d,
    input  logic                    s_e,
    input  logic                    s_f,
    input  logic                    s_g,
    input  logic                    dp,
    input  logic [NUM_DIGITS-1:0]   anode,
    input  logic                    clear,
    output logic [4*NUM_DIGITS-1:0] value,
    output logic [NUM_DIGITS-1:0]   dp_out,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    frame_valid,
    output logic                    pattern_err
);

    localparam int              CW       = $clog2(STABLE_CYCLES + 1);
    localparam int              SW       = NUM_DIGITS + 8;
    localparam logic            INV      = (ACTIVE_LOW != 0);
    localparam logic [CW-1:0]   CNT_MAX  = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {IDLE, COUNT, HOLD} state_t;

    state_t                  state;
    logic [CW-1:0]           cnt;
    logic [6:0]              seg_q;
    logic                    dp_q;
    logic [NUM_DIGITS-1:0]   anode_q;
    logic [SW-1:0]           ref_q;

    logic [6:0]              seg_n;
    logic                    dp_n;
    logic [NUM_DIGITS-1:0]   anode_n;
    logic                    selected;
    logic [SW-1:0]           sample;
    logic [NUM_DIGITS-1:0]   ref_anode;
    logic                    ref_dp;
    logic [6:0]              ref_seg;
    logic                    glyph_ok;
    logic [3:0]              glyph_nib;

    // {g,f,e,d,c,b,a} active-high to {valid, nibble}
    function automatic logic [4:0] decode(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'h3F: r = 5'h10;  7'h06: r = 5'h11;  7'h5B: r = 5'h12;  7'h4F: r = 5'h13;
            7'h66: r = 5'h14;  7'h6D: r = 5'h15;  7'h7D: r = 5'h16;  7'h07: r = 5'h17;
            7'h7F: r = 5'h18;  7'h6F: r = 5'h19;  7'h77: r = 5'h1A;  7'h7C: r = 5'h1B;
            7'h39: r = 5'h1C;  7'h5E: r = 5'h1D;  7'h79: r = 5'h1E;  7'h71: r = 5'h1F;
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    // Everything downstream sees the registered, active-high copy of the pins.
    assign seg_n    = seg_q ^ {7{INV}};
    assign dp_n     = dp_q ^ INV;
    assign anode_n  = anode_q ^ {NUM_DIGITS{INV}};
    // Exactly one digit driven; zero or several anodes is treated as blanking.
    assign selected = (anode_n != '0) && ((anode_n & (anode_n - 1'b1)) == '0);
    assign sample   = {anode_n, dp_n, seg_n};

    assign {ref_anode, ref_dp, ref_seg} = ref_q;
    assign {glyph_ok, glyph_nib}        = decode(ref_seg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q       <= '0;
            dp_q        <= 1'b0;
            anode_q     <= '0;
            ref_q       <= '0;
            cnt         <= '0;
            state       <= IDLE;
            value       <= '0;
            dp_out      <= '0;
            digit_valid <= '0;
            frame_valid <= 1'b0;
            pattern_err <= 1'b0;
        end else begin
            seg_q       <= {s_g, s_f, s_e, s_d, s_c, s_b, s_a};
            dp_q        <= dp;
            anode_q     <= anode;
            pattern_err <= 1'b0;
            frame_valid <= &digit_valid;

            if (clear) begin
                // Wins over any capture due on this edge.
                value       <= '0;
                dp_out      <= '0;
                digit_valid <= '0;
                frame_valid <= 1'b0;
                cnt         <= '0;
                state       <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (selected) begin
                            ref_q <= sample;
                            cnt   <= CNT_ONE;
                            state <= COUNT;
                        end
                    end
                    COUNT: begin
                        if (sample == ref_q) begin
                            if (cnt == CNT_MAX) begin
                                // Dwell satisfied: commit once, then park in HOLD.
                                for (int i = 0; i < NUM_DIGITS; i++) begin
                                    if (ref_anode[i]) begin
                                        if (glyph_ok) begin
                                            value[4*i +: 4] <= glyph_nib;
                                            dp_out[i]       <= ref_dp;
                                            digit_valid[i]  <= 1'b1;
                                        end else begin
                                            digit_valid[i]  <= 1'b0;
                                        end
                                    end
                                end
                                pattern_err <= ~glyph_ok;
                                state       <= HOLD;
                            end else begin
                                cnt <= cnt + CNT_ONE;
                            end
                        end else if (selected) begin
                            ref_q <= sample;
                            cnt   <= CNT_ONE;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    HOLD: begin
                        if (sample != ref_q) begin
                            if (selected) begin
                                ref_q <= sample;
                                cnt   <= CNT_ONE;
                                state <= COUNT;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seg7_display_reader.sv
module tb_seg7_display_reader;

    localparam int N = 4;
    localparam int S = 4;
    localparam logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [6:0]     seg_pin = 7'h7F;
    logic           dp_pin = 1'b1;
    logic [N-1:0]   an_pin = '1;
    logic           clear = 1'b0;
    logic [4*N-1:0] value;
    logic [N-1:0]   dp_out;
    logic [N-1:0]   digit_valid;
    logic           frame_valid;
    logic           pattern_err;

    int vectors = 0;
    int miscompares = 0;
    int perr_seen = 0;

    seg7_display_reader #(.NUM_DIGITS(N), .STABLE_CYCLES(S), .ACTIVE_LOW(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_a(seg_pin[0]), .s_b(seg_pin[1]), .s_c(seg_pin[2]), .s_d(seg_pin[3]),
        .s_e(seg_pin[4]), .s_f(seg_pin[5]), .s_g(seg_pin[6]),
        .dp(dp_pin), .anode(an_pin), .clear(clear),
        .value(value), .dp_out(dp_out), .digit_valid(digit_valid),
        .frame_valid(frame_valid), .pattern_err(pattern_err)
    );

    always #5 clk = ~clk;

    // Reference model: a digit is captured when the same selected pattern has
    // been seen on exactly S+1 consecutive samples; the DUT sees pins one edge late.
    logic [4*N-1:0] e_val = '0;
    logic [N-1:0]   e_dp = '0;
    logic [N-1:0]   e_dv = '0;
    logic           e_frame = 1'b0;
    logic           e_perr = 1'b0;
    int             run = 0;
    logic [N+7:0]   last_key = '0;
    logic [N-1:0]   p_an = '1;      // previous pins; power-up copy reads as blanking
    logic [6:0]     p_sg = '1;
    logic           p_dp = 1'b1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_val = '0; e_dp = '0; e_dv = '0; e_frame = 1'b0; e_perr = 1'b0;
            run = 0; p_an = '1; p_sg = '1; p_dp = 1'b1;
        end else begin
            logic [N-1:0] an;
            logic [6:0]   sg;
            logic         d;
            logic [N+7:0] key;
            an = ~p_an; sg = ~p_sg; d = ~p_dp;
            key = {an, d, sg};
            p_an = an_pin; p_sg = seg_pin; p_dp = dp_pin;
            e_perr = 1'b0;
            if (clear) begin
                e_val = '0; e_dp = '0; e_dv = '0; e_frame = 1'b0; run = 0;
            end else begin
                e_frame = &e_dv;
                if ($countones(an) == 1) begin
                    if (run > 0 && key == last_key) run++;
                    else run = 1;
                    last_key = key;
                    if (run == S + 1) begin
                        int  idx;
                        int  nib;
                        idx = 0; nib = -1;
                        for (int i = 0; i < N; i++) if (an[i]) idx = i;
                        for (int j = 0; j < 16; j++) if (GLYPH[j] == sg) nib = j;
                        if (nib >= 0) begin
                            e_val[4*idx +: 4] = 4'(nib);
                            e_dp[idx] = d;
                            e_dv[idx] = 1'b1;
                        end else begin
                            e_perr = 1'b1;
                            e_dv[idx] = 1'b0;
                        end
                    end
                end else begin
                    run = 0;
                end
            end
        end
    end

    // Cycle-by-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        vectors++;
        if (pattern_err) perr_seen++;
        if (value !== e_val || dp_out !== e_dp || digit_valid !== e_dv ||
            frame_valid !== e_frame || pattern_err !== e_perr) begin
            miscompares++;
            $display("FAIL model t=%0t: got value=%h dp=%b dv=%b fv=%b perr=%b, want value=%h dp=%b dv=%b fv=%b perr=%b",
                     $time, value, dp_out, digit_valid, frame_valid, pattern_err,
                     e_val, e_dp, e_dv, e_frame, e_perr);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Drive one digit (active-high view) for n edges.
    task automatic apply(input logic [N-1:0] an_hi, input logic [6:0] sg_hi, input logic d, input int n);
        @(negedge clk); #1;
        an_pin = ~an_hi; seg_pin = ~sg_hi; dp_pin = ~d;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic blank(input int n);
        apply('0, 7'h00, 1'b0, n);
    endtask

    int p0;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_value", 32'(value), 32'h0);
        check("reset_flags", {27'd0, dp_out, frame_valid}, 32'h0);
        @(negedge clk); #1; rst_n = 1'b1;
        blank(2);

        // 1) digit 0 shows "5": one edge short, then captured
        p0 = perr_seen;
        apply(4'b0001, GLYPH[5], 1'b0, 5);
        check("t1_not_yet", 32'(digit_valid), 32'h0);
        @(posedge clk); #1;
        check("t1_value", 32'(value[3:0]), 32'h5);
        check("t1_dv", 32'(digit_valid), 32'b0001);
        check("t1_no_perr", perr_seen - p0, 0);

        // 2) scan 1,2,3,F
        apply(4'b0001, GLYPH[1], 1'b0, 8);
        apply(4'b0010, GLYPH[2], 1'b0, 8);
        apply(4'b0100, GLYPH[3], 1'b0, 8);
        apply(4'b1000, GLYPH[15], 1'b0, 8);
        check("t2_value", 32'(value), 32'hF321);
        check("t2_dv", 32'(digit_valid), 32'hF);
        check("t2_frame", 32'(frame_valid), 32'h1);

        // 3) non-glyph on digit 2
        p0 = perr_seen;
        apply(4'b0100, 7'h49, 1'b0, 6);
        blank(2);
        check("t3_perr_once", perr_seen - p0, 1);
        check("t3_dv", 32'(digit_valid), 32'b1011);
        check("t3_value_kept", 32'(value[11:8]), 32'h3);

        // 4) toggling pattern and multi-hot anode
        for (int i = 0; i < 8; i++) apply(4'b0010, (i % 2 == 0) ? GLYPH[6] : GLYPH[9], 1'b1, 3);
        apply(4'b0011, GLYPH[8], 1'b0, 10);
        check("t4_value", 32'(value), 32'hF321);
        check("t4_dv", 32'(digit_valid), 32'b1011);

        // 5) clear on the capture edge
        apply(4'b0001, GLYPH[8], 1'b1, 5);
        @(negedge clk); #1; clear = 1'b1;
        @(posedge clk); #1;
        check("t5_value", 32'(value), 32'h0);
        check("t5_flags", {27'd0, dp_out, frame_valid}, 32'h0);
        check("t5_dv", 32'(digit_valid), 32'h0);
        @(negedge clk); #1; clear = 1'b0;
        blank(2);

        // 6) reset mid-dwell
        apply(4'b0001, GLYPH[5], 1'b0, 2);
        @(negedge clk); #1; rst_n = 1'b0;
        #1;
        check("t6_in_reset", 32'(value), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk); #1; rst_n = 1'b1;
        repeat (5) @(posedge clk); #1;
        check("t6_not_yet", 32'(digit_valid), 32'h0);
        @(posedge clk); #1;
        check("t6_value", 32'(value[3:0]), 32'h5);
        check("t6_dv", 32'(digit_valid), 32'b0001);

        // Random traffic against the model
        for (int e = 0; e < 300; e++) begin
            int r;
            logic [N-1:0] an;
            logic [6:0] sg;
            r = $urandom_range(0, 99);
            an = 4'b0001 << $urandom_range(0, N - 1);
            sg = (r < 80) ? GLYPH[$urandom_range(0, 15)] : 7'($urandom);
            if (r >= 90) an = 4'($urandom);
            apply(an, sg, 1'($urandom), $urandom_range(1, 9));
            r = $urandom_range(0, 99);
            if (r < 4) begin
                @(negedge clk); #1; clear = 1'b1;
                @(negedge clk); #1; clear = 1'b0;
            end else if (r < 6) begin
                @(negedge clk); #1; rst_n = 1'b0;
                @(negedge clk); #1; rst_n = 1'b1;
            end
        end
        blank(2);
        @(negedge clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
